// File: rtl/sseg_pkg.sv
// Shared constants and types for the seven-segment scan path.
// NUM_DIGITS/POS_W size the frame and position counter; DIGIT_W/DP_BIT
// describe the {dp, bcd} digit code sent to the decoder.
package sseg_pkg;

  localparam int          NUM_DIGITS = 6;
  localparam int          POS_W      = 3;
  localparam logic [3:0]  BCD_MAX    = 4'd9;
  localparam int          DIGIT_W    = 5;
  localparam int          DP_BIT     = 4;

  typedef enum logic [POS_W-1:0] {
    POS0 = 3'd0,
    POS1 = 3'd1,
    POS2 = 3'd2,
    POS3 = 3'd3,
    POS4 = 3'd4,
    POS5 = 3'd5
  } pos_e;

  // Codes above 9 are undefined in the decoder, so they are forced to 0.
  function automatic logic [3:0] sanitize(input logic [3:0] nib);
    return (nib > BCD_MAX) ? 4'd0 : nib;
  endfunction

endpackage

// File: rtl/tick_div.sv
// Free-running clock divider.
// Ports:
//   clk  - system clock
//   rst  - synchronous active-high reset, counter returns to 0
//   tick - high for one cycle every DIV cycles (when the counter is DIV-1)
module tick_div #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  if (DIV < 2) begin : g_div_check
    $error("tick_div: DIV must be >= 2");
  end

  localparam int CNT_W = (DIV > 2) ? $clog2(DIV) : 1;

  logic [CNT_W-1:0] cnt;

  assign tick = (cnt == CNT_W'(DIV - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/sseg_scan.sv
// Six-digit BCD display scanner with double-buffered frames.
// Ports:
//   clk, rst     - clock, synchronous active-high reset
//   value_in     - six BCD nibbles, nibble k shown at position k (0 = leftmost)
//   dp_in        - decimal point enables, bit k for position k
//   load         - one-cycle strobe capturing value_in/dp_in into the pending buffer
//   pending      - a captured frame is waiting for the next frame boundary
//   digit        - {dp, bcd} for the current position
//   digit_pos    - current position 0..5
//   frame_start  - one-cycle pulse in the cycle digit_pos becomes 0
//   bad_bcd      - sticky: a loaded nibble exceeded 9 (cleared only by rst)
module sseg_scan
  import sseg_pkg::*;
#(
  parameter int CLK_HZ  = 50000000,
  parameter int SCAN_HZ = 1000
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [4*NUM_DIGITS-1:0]       value_in,
  input  logic [NUM_DIGITS-1:0]         dp_in,
  input  logic                          load,
  output logic                          pending,
  output logic [DIGIT_W-1:0]            digit,
  output logic [POS_W-1:0]              digit_pos,
  output logic                          frame_start,
  output logic                          bad_bcd
);

  localparam int DIV = CLK_HZ / SCAN_HZ;

  logic tick;

  tick_div #(.DIV(DIV)) u_div (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  pos_e                      pos_q, pos_d, pos_nxt;
  logic [4*NUM_DIGITS-1:0]   act_val_q, act_val_d, pend_val_q, pend_val_d;
  logic [NUM_DIGITS-1:0]     act_dp_q, act_dp_d, pend_dp_q, pend_dp_d;
  logic                      pending_q, pending_d;
  logic [DIGIT_W-1:0]        digit_q, digit_d;
  logic                      fs_q, fs_d;
  logic                      bad_q, bad_d;
  logic [4*NUM_DIGITS-1:0]   load_val;
  logic                      load_bad;
  logic                      wrap, swap;
  logic [POS_W-1:0]          nidx;

  always_ff @(posedge clk) begin
    if (rst) begin
      pos_q      <= POS0;
      act_val_q  <= '0;
      act_dp_q   <= '0;
      pend_val_q <= '0;
      pend_dp_q  <= '0;
      pending_q  <= 1'b0;
      digit_q    <= '0;
      fs_q       <= 1'b0;
      bad_q      <= 1'b0;
    end else begin
      pos_q      <= pos_d;
      act_val_q  <= act_val_d;
      act_dp_q   <= act_dp_d;
      pend_val_q <= pend_val_d;
      pend_dp_q  <= pend_dp_d;
      pending_q  <= pending_d;
      digit_q    <= digit_d;
      fs_q       <= fs_d;
      bad_q      <= bad_d;
    end
  end

  always_comb begin
    load_val = '0;
    load_bad = 1'b0;
    for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
      load_val[4*k +: 4] = sanitize(value_in[4*k +: 4]);
      if (value_in[4*k +: 4] > BCD_MAX) load_bad = 1'b1;
    end

    case (pos_q)
      POS0:    pos_nxt = POS1;
      POS1:    pos_nxt = POS2;
      POS2:    pos_nxt = POS3;
      POS3:    pos_nxt = POS4;
      POS4:    pos_nxt = POS5;
      default: pos_nxt = POS0;
    endcase

    wrap = tick && (pos_q == POS5);
    swap = wrap && pending_q;
    pos_d = tick ? pos_nxt : pos_q;
    nidx  = pos_nxt;

    // Swap takes the old pending buffer; a coincident load refills it.
    act_val_d  = swap ? pend_val_q : act_val_q;
    act_dp_d   = swap ? pend_dp_q  : act_dp_q;
    pend_val_d = load ? load_val   : pend_val_q;
    pend_dp_d  = load ? dp_in      : pend_dp_q;
    pending_d  = load ? 1'b1 : (swap ? 1'b0 : pending_q);

    // Digit is looked up from the post-swap frame so position 0 of a new
    // frame is shown on the same edge as the swap.
    digit_d = digit_q;
    if (tick) begin
      digit_d[DP_BIT]  = act_dp_d[nidx];
      digit_d[3:0]     = act_val_d[{nidx, 2'b00} +: 4];
    end

    fs_d  = wrap;
    bad_d = bad_q | (load & load_bad);
  end

  assign pending     = pending_q;
  assign digit       = digit_q;
  assign digit_pos   = pos_q;
  assign frame_start = fs_q;
  assign bad_bcd     = bad_q;

endmodule
